// File: rtl/qsys_gpio_pkg.sv
// Shared register map, edge-mode encodings and watchdog control layout for the GPIO/watchdog block.
package qsys_gpio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  // Avalon-MM word addresses
  typedef enum logic [ADDR_W-1:0] {
    ADDR_DATA      = 3'd0,
    ADDR_INPUT     = 3'd1,
    ADDR_IRQ_MASK  = 3'd2,
    ADDR_EDGE_CAP  = 3'd3,
    ADDR_OUTSET    = 3'd4,
    ADDR_OUTCLR    = 3'd5,
    ADDR_WDT_CTRL  = 3'd6,
    ADDR_WDT_COUNT = 3'd7
  } gpio_addr_e;

  // Edge capture modes
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // WDT_CTRL register image: bit1 = tripped, bit0 = enable
  typedef struct packed {
    logic tripped;
    logic enable;
  } wdt_ctrl_t;

endpackage

// File: rtl/qsys_gpio_sync.sv
// Two-flop input synchroniser with an edge detector on the synchronised value.
module qsys_gpio_sync
  import qsys_gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_c_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] prev_q;

  // Metastability chain plus one-cycle history of the synchronised value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;

  // Edge pulse on the synchronised value, selected by EDGE_MODE
  always_comb begin
    edge_c_o = s2_q & ~prev_q;
    case (EDGE_MODE)
      EDGE_FALL: edge_c_o = ~s2_q & prev_q;
      EDGE_ANY:  edge_c_o = s2_q ^ prev_q;
      default:   edge_c_o = s2_q & ~prev_q;
    endcase
  end

endmodule

// File: rtl/qsys_gpio_wdt.sv
// Avalon-MM GPIO with edge-capture interrupts and an output watchdog that forces a safe value on timeout.
module qsys_gpio_wdt
  import qsys_gpio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SAFE_VALUE  = '0,
  parameter int unsigned      EDGE_MODE   = EDGE_RISE,
  parameter int unsigned      WDT_CYCLES  = 50_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  localparam int unsigned      CNT_W      = $clog2(WDT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WDT_CYCLES - 1);

  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q,  cap_d;
  wdt_ctrl_t        ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_edge;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic             out_wr;
  logic             ctrl_reload;
  gpio_addr_e       addr_e;
  logic             unused_wdata;

  qsys_gpio_sync #(
    .WIDTH     (WIDTH),
    .EDGE_MODE (EDGE_MODE)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .din_i    (in_port),
    .sync_o   (in_sync),
    .edge_c_o (in_edge)
  );

  assign addr_e       = gpio_addr_e'(address);
  assign wr_en        = chipselect & ~write_n;
  assign wd           = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Next-state: register writes, edge capture, watchdog countdown and trip
  always_comb begin
    out_d       = out_q;
    mask_d      = mask_q;
    ctrl_d      = ctrl_q;
    cnt_d       = cnt_q;
    cap_clr     = '0;
    out_wr      = 1'b0;
    ctrl_reload = 1'b0;

    if (wr_en) begin
      case (addr_e)
        ADDR_DATA: begin
          if (!ctrl_q.tripped) begin
            out_d  = wd;
            out_wr = 1'b1;
          end
        end
        ADDR_OUTSET: begin
          if (!ctrl_q.tripped) begin
            out_d  = out_q | wd;
            out_wr = 1'b1;
          end
        end
        ADDR_OUTCLR: begin
          if (!ctrl_q.tripped) begin
            out_d  = out_q & ~wd;
            out_wr = 1'b1;
          end
        end
        ADDR_IRQ_MASK: mask_d  = wd;
        ADDR_EDGE_CAP: cap_clr = wd;
        ADDR_WDT_CTRL: begin
          ctrl_d.enable = writedata[0];
          if (writedata[1]) begin
            ctrl_d.tripped = 1'b0;
          end
          ctrl_reload = writedata[0] | (writedata[1] & ctrl_q.tripped);
        end
        default: ;
      endcase
    end

    // A new edge beats a same-cycle write-1-to-clear
    cap_d = (cap_q & ~cap_clr) | in_edge;

    // Any reload pre-empts expiry, so a kick in the expiry cycle never trips
    if (out_wr || ctrl_reload) begin
      cnt_d = CNT_RELOAD;
    end else if (ctrl_q.enable && !ctrl_q.tripped) begin
      if (cnt_q == '0) begin
        ctrl_d.tripped = 1'b1;
        out_d          = SAFE_VALUE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_VALUE;
      mask_q <= '0;
      cap_q  <= '0;
      ctrl_q <= '0;
      cnt_q  <= CNT_RELOAD;
    end else begin
      out_q  <= out_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  // Zero-wait-state read mux; write-only addresses read as zero
  always_comb begin
    readdata = '0;
    case (addr_e)
      ADDR_DATA:      readdata = DATA_W'(out_q);
      ADDR_INPUT:     readdata = DATA_W'(in_sync);
      ADDR_IRQ_MASK:  readdata = DATA_W'(mask_q);
      ADDR_EDGE_CAP:  readdata = DATA_W'(cap_q);
      ADDR_WDT_CTRL:  readdata = DATA_W'(ctrl_q);
      ADDR_WDT_COUNT: readdata = DATA_W'(cnt_q);
      default:        readdata = '0;
    endcase
  end

  assign out_port = out_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_qsys_gpio_wdt.sv
// Bench for qsys_gpio_wdt: directed scenarios plus randomized traffic against a rule-level reference model.
`timescale 1ns/1ps
module tb_qsys_gpio_wdt;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned WDT_CYCLES = 16;
  localparam int unsigned EDGE_MODE  = 0;
  localparam logic [3:0]  SAFE       = 4'h0;
  localparam logic [3:0]  RSTV       = 4'h5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = '0;
  logic [3:0]  out_port;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [3:0] m_out, m_mask, m_cap;
  bit         m_en, m_trip;
  int         m_cnt;
  logic [3:0] pin_hist [3];   // [0] = pin sampled at the latest edge

  qsys_gpio_wdt #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RSTV),
    .SAFE_VALUE  (SAFE),
    .EDGE_MODE   (EDGE_MODE),
    .WDT_CYCLES  (WDT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_out  = RSTV;
    m_mask = '0;
    m_cap  = '0;
    m_en   = 1'b0;
    m_trip = 1'b0;
    m_cnt  = WDT_CYCLES - 1;
    for (int i = 0; i < 3; i++) pin_hist[i] = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {28'b0, m_out};
      3'd1:    return {28'b0, pin_hist[1]};
      3'd2:    return {28'b0, m_mask};
      3'd3:    return {28'b0, m_cap};
      3'd6:    return {30'b0, m_trip, m_en};
      3'd7:    return 32'(m_cnt);
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the block, from the register-map rules, using pre-edge values
  function automatic void model_step();
    logic       wr;
    logic [3:0] wd, s_now, s_old, edges, clr, n_out, n_mask, n_cap;
    bit         out_wr, ctrl_wr, reload, expire, n_en, n_trip;
    int         n_cnt;
    wr      = chipselect && !write_n;
    wd      = writedata[3:0];
    out_wr  = wr && !m_trip && (address == 3'd0 || address == 3'd4 || address == 3'd5);
    ctrl_wr = wr && address == 3'd6;
    reload  = out_wr || (ctrl_wr && (writedata[0] || (writedata[1] && m_trip)));
    expire  = m_en && !m_trip && m_cnt == 0 && !reload;
    s_now   = pin_hist[1];
    s_old   = pin_hist[2];
    case (EDGE_MODE)
      1:       edges = ~s_now & s_old;
      2:       edges = s_now ^ s_old;
      default: edges = s_now & ~s_old;
    endcase
    clr    = (wr && address == 3'd3) ? wd : 4'h0;
    n_cap  = (m_cap & ~clr) | edges;
    n_mask = (wr && address == 3'd2) ? wd : m_mask;
    n_out  = m_out;
    if (expire) n_out = SAFE;
    else if (out_wr) begin
      if (address == 3'd0)      n_out = wd;
      else if (address == 3'd4) n_out = m_out | wd;
      else                      n_out = m_out & ~wd;
    end
    n_en   = ctrl_wr ? writedata[0] : m_en;
    n_trip = expire ? 1'b1 : ((ctrl_wr && writedata[1]) ? 1'b0 : m_trip);
    if (reload)                         n_cnt = WDT_CYCLES - 1;
    else if (m_en && !m_trip && m_cnt > 0) n_cnt = m_cnt - 1;
    else                                n_cnt = m_cnt;
    m_out = n_out; m_mask = n_mask; m_cap = n_cap;
    m_en = n_en; m_trip = n_trip; m_cnt = n_cnt;
    pin_hist[2] = pin_hist[1];
    pin_hist[1] = pin_hist[0];
    pin_hist[0] = in_port;
  endfunction

  // Compare pins and every readable register against the model (low clock phase)
  task automatic check_state(input string tag);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check($sformatf("%s out_port", tag), 32'(out_port), 32'(m_out));
    check($sformatf("%s irq", tag), 32'(irq), 32'(|(m_cap & m_mask)));
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      check($sformatf("%s rd%0d", tag, a), readdata, model_read(3'(a)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check_state("model");
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset values
    check("rst out_port", 32'(out_port), 32'h5);
    check("rst irq", 32'(irq), 32'h0);
    rd(3'd7, v); check("rst count", v, 32'd15);
    check_state("reset");

    // DATA / OUTSET / OUTCLR
    wr(3'd0, 32'hA); check("data out", 32'(out_port), 32'hA);
    wr(3'd4, 32'h1); check("outset out", 32'(out_port), 32'hB);
    wr(3'd5, 32'h8); check("outclr out", 32'(out_port), 32'h3);

    // Edge capture and interrupt latency
    wr(3'd2, 32'h2);
    in_port = 4'h2;
    tick(); tick();
    check("edge irq early", 32'(irq), 32'h0);
    tick();
    check("edge irq", 32'(irq), 32'h1);
    rd(3'd3, v); check("edge cap", v, 32'h2);
    wr(3'd3, 32'h2);
    check("edge clr irq", 32'(irq), 32'h0);

    // Watchdog expiry
    wr(3'd0, 32'hF);
    wr(3'd6, 32'h1);
    repeat (15) tick();
    rd(3'd6, v); check("wdt pre-trip ctrl", v, 32'h1);
    check("wdt pre-trip out", 32'(out_port), 32'hF);
    tick();
    rd(3'd6, v); check("wdt trip ctrl", v, 32'h3);
    check("wdt trip out", 32'(out_port), 32'h0);
    wr(3'd0, 32'h3);
    check("wdt ignored write", 32'(out_port), 32'h0);

    // Clear tripped, then DATA works again
    wr(3'd6, 32'h3);
    rd(3'd6, v); check("clr ctrl", v, 32'h1);
    check("clr out", 32'(out_port), 32'h0);
    wr(3'd0, 32'h6);
    check("post-clr data", 32'(out_port), 32'h6);

    // DATA write in the expiry cycle wins
    repeat (15) tick();
    rd(3'd7, v); check("expiry count", v, 32'd0);
    wr(3'd0, 32'h9);
    check("kick out", 32'(out_port), 32'h9);
    rd(3'd6, v); check("kick ctrl", v, 32'h1);
    rd(3'd7, v); check("kick count", v, 32'd15);

    // Reset while tripped
    repeat (16) tick();
    rd(3'd6, v); check("pre-rst trip", v, 32'h3);
    do_reset();
    check("rst2 out_port", 32'(out_port), 32'h5);
    rd(3'd6, v); check("rst2 ctrl", v, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      chipselect = ($urandom_range(0, 9) < 2);
      write_n    = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if ($urandom_range(0, 5) == 0) in_port = 4'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
